// File: rtl/pad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_ctrl_pkg
// Description : Shared definitions for the user pad controller. Contains the
//               register word offsets, the register-window address mask, the
//               Wishbone FSM state type and small helper functions (byte-select
//               expansion and the STAT write-1-to-clear update).
// Revision    : 1.0 - initial release
// ============================================================================
package pad_ctrl_pkg;

  // 32-byte register window: low five address bits select within it
  localparam logic [31:0] ADDR_MASK = 32'h0000_001F;

  // Word offsets, taken from address bits [4:2]
  localparam logic [2:0] REG_MODE = 3'd0;
  localparam logic [2:0] REG_OUT  = 3'd1;
  localparam logic [2:0] REG_OEB  = 3'd2;
  localparam logic [2:0] REG_IN   = 3'd3;
  localparam logic [2:0] REG_RISE = 3'd4;
  localparam logic [2:0] REG_FALL = 3'd5;
  localparam logic [2:0] REG_STAT = 3'd6;
  localparam logic [2:0] REG_ID   = 3'd7;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_t;

  // Expand the four byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  // New events are ORed in after the clear, so a same-cycle event survives
  function automatic logic [31:0] stat_w1c(input logic [31:0] cur,
                                           input logic [31:0] clr,
                                           input logic [31:0] evt);
    return (cur & ~clr) | evt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/user_proj_pad_ctrl_pad_sync.sv
`default_nettype none
// ============================================================================
// Module      : pad_sync
// Description : Per-pad input synchroniser (STAGES flops deep) followed by a
//               previous-sample flop used for edge detection.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               din[WIDTH]      - asynchronous pad inputs
//               sync_out[WIDTH] - synchronised inputs
//               rise/fall[WIDTH]- single-cycle edge flags on sync_out
// Revision    : 1.0 - initial release
// ============================================================================
module pad_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Flat shift chain: stage 0 in the low slice, newest sample shifts upward
  logic [STAGES*WIDTH-1:0] chain;
  logic [WIDTH-1:0]        prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[(STAGES-1)*WIDTH-1:0], din};
      prev  <= sync_out;
    end
  end

  assign sync_out = chain[STAGES*WIDTH-1 -: WIDTH];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule
`default_nettype wire

// File: rtl/user_proj_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : user_proj_pad_ctrl
// Description : Pad controller between the user CPU core and the Caravel IO
//               pads. Per-pad ownership mux (core vs. Wishbone override),
//               synchronised pad inputs, edge detection with a maskable level
//               interrupt, and a 32-byte Wishbone register window.
// Ports       : wb_clk_i/wb_rst_i - clock, asynchronous active-high reset
//               wbs_*             - Wishbone slave
//               core_out/core_oeb - CPU pad drive; core_in raw io_in to CPU
//               io_in/io_out/io_oeb - pad slice
//               irq_o             - registered level interrupt (|STAT)
// Revision    : 1.0 - initial release
// ============================================================================
module user_proj_pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int          PAD_COUNT    = 32,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] WB_BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE     = 32'h5043_0001
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [PAD_COUNT-1:0] core_out,
  input  logic [PAD_COUNT-1:0] core_oeb,
  output logic [PAD_COUNT-1:0] core_in,
  input  logic [PAD_COUNT-1:0] io_in,
  output logic [PAD_COUNT-1:0] io_out,
  output logic [PAD_COUNT-1:0] io_oeb,
  output logic                 irq_o
);

  logic [PAD_COUNT-1:0] mode_q, out_q, oeb_q, rise_en_q, fall_en_q, stat_q;
  logic [PAD_COUNT-1:0] sync_in, rise, fall;
  wb_state_t            state;

  pad_sync #(
    .WIDTH  (PAD_COUNT),
    .STAGES (SYNC_STAGES)
  ) u_pad_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .din      (io_in),
    .sync_out (sync_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Pad muxing and raw passthrough are purely combinational
  assign core_in = io_in;
  assign io_out  = (mode_q & out_q) | (~mode_q & core_out);
  assign io_oeb  = (mode_q & oeb_q) | (~mode_q & core_oeb);

  // Decode
  logic                 req, in_window, wr_fire;
  logic [2:0]           reg_sel;
  logic [31:0]          wmask32;
  logic [PAD_COUNT-1:0] wmask, wdata;

  assign req       = wbs_stb_i & wbs_cyc_i;
  assign in_window = (wbs_adr_i & ~ADDR_MASK) == (WB_BASE_ADDR & ~ADDR_MASK);
  assign reg_sel   = wbs_adr_i[4:2];
  // A write commits only on the edge that also raises ack
  assign wr_fire   = (state == WB_IDLE) & req & wbs_we_i & in_window;
  assign wmask32   = byte_mask(wbs_sel_i);
  assign wmask     = wmask32[PAD_COUNT-1:0];
  assign wdata     = wbs_dat_i[PAD_COUNT-1:0];

  // Read mux, zero-extended; unmapped or out-of-window reads return 0
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (in_window) begin
      case (reg_sel)
        REG_MODE: rd_word[PAD_COUNT-1:0] = mode_q;
        REG_OUT:  rd_word[PAD_COUNT-1:0] = out_q;
        REG_OEB:  rd_word[PAD_COUNT-1:0] = oeb_q;
        REG_IN:   rd_word[PAD_COUNT-1:0] = sync_in;
        REG_RISE: rd_word[PAD_COUNT-1:0] = rise_en_q;
        REG_FALL: rd_word[PAD_COUNT-1:0] = fall_en_q;
        REG_STAT: rd_word[PAD_COUNT-1:0] = stat_q;
        REG_ID:   rd_word = ID_VALUE;
        default:  rd_word = '0;
      endcase
    end
  end

  // STAT next-state through the shared W1C helper
  logic [31:0] stat_cur32, stat_clr32, stat_evt32, stat_nxt32;
  always_comb begin
    stat_cur32 = '0;
    stat_clr32 = '0;
    stat_evt32 = '0;
    stat_cur32[PAD_COUNT-1:0] = stat_q;
    stat_evt32[PAD_COUNT-1:0] = (rise & rise_en_q) | (fall & fall_en_q);
    if (wr_fire && reg_sel == REG_STAT) begin
      stat_clr32[PAD_COUNT-1:0] = wdata & wmask;
    end
    stat_nxt32 = stat_w1c(stat_cur32, stat_clr32, stat_evt32);
  end

  // Register bank
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mode_q    <= '0;
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_fire) begin
        case (reg_sel)
          REG_MODE: mode_q    <= (mode_q    & ~wmask) | (wdata & wmask);
          REG_OUT:  out_q     <= (out_q     & ~wmask) | (wdata & wmask);
          REG_OEB:  oeb_q     <= (oeb_q     & ~wmask) | (wdata & wmask);
          REG_RISE: rise_en_q <= (rise_en_q & ~wmask) | (wdata & wmask);
          REG_FALL: fall_en_q <= (fall_en_q & ~wmask) | (wdata & wmask);
          default:  ;
        endcase
      end
      stat_q <= stat_nxt32[PAD_COUNT-1:0];
      irq_o  <= |stat_q;
    end
  end

  // Wishbone FSM: one ack cycle, then a mandatory idle cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= WB_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (req) begin
            state     <= WB_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? 32'h0 : rd_word;
          end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
          end
        end
        default: begin
          state     <= WB_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_user_proj_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_proj_pad_ctrl
// Description : Directed self-checking bench for user_proj_pad_ctrl. Expected
//               read data is queued when a read is issued and popped when the
//               DUT acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_proj_pad_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] IDV  = 32'h5043_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] core_out = '0, core_oeb = '0, io_in = '0;
  logic [31:0] core_in, io_out, io_oeb;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  user_proj_pad_ctrl #(
    .PAD_COUNT(32), .SYNC_STAGES(2), .WB_BASE_ADDR(BASE), .ID_VALUE(IDV)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; checks ack is exactly one cycle wide
  task automatic wb(input string tag, input bit w, input logic [31:0] off,
                    input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = off; wdat = d; sel = s;
    if (!w) sb.push_back(exp);
    @(posedge clk); #1;
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    if (!w) begin
      e = sb.pop_front();
      chk(tag, rdat, e);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_lo"}, {31'b0, ack}, 32'd0);
    chk({tag, "_dat_lo"}, rdat, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    wb(tag, 1'b0, off, 32'h0, 4'hF, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    wb(tag, 1'b1, off, d, s, 32'h0);
  endtask

  initial begin
    core_out = 32'hF0F0_F0F0;
    core_oeb = 32'hFFFF_0001;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_io_out", io_out, 32'hF0F0_F0F0);
    chk("rst_io_oeb", io_oeb, 32'hFFFF_0001);
    @(negedge clk); rst = 1'b0;

    // Reset mid-write: take ownership first so the revert is visible
    wr("w_mode_all", BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
    wr("w_oeb_0", BASE + 32'h08, 32'h0, 4'hF);
    chk("own_oeb", io_oeb, 32'h0);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h04; wdat = 32'hFFFF_FFFF; sel = 4'hF;
    #2 rst = 1'b1;
    #1 chk("rst_async_oeb", io_oeb, 32'hFFFF_0001);
    chk("rst_async_out", io_out, 32'hF0F0_F0F0);
    @(posedge clk); #1;
    chk("rst_mid_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_ack", {31'b0, ack}, 32'd0);
    rd("r_out_rst", BASE + 32'h04, 32'h0);
    rd("r_oeb_rst", BASE + 32'h08, 32'hFFFF_FFFF);
    rd("r_mode_rst", BASE + 32'h00, 32'h0);

    // Ownership of pad 0
    wr("w_mode1", BASE + 32'h00, 32'h1, 4'hF);
    wr("w_out1", BASE + 32'h04, 32'h1, 4'hF);
    wr("w_oeb0", BASE + 32'h08, 32'h0, 4'hF);
    chk("own_io_out", io_out, 32'hF0F0_F0F1);
    chk("own_io_oeb", io_oeb, 32'hFFFF_0000);
    core_out = 32'h0F0F_0F0E;
    #1 chk("own_follow", io_out, 32'h0F0F_0F0F);
    chk("core_in", core_in, io_in);

    // Byte-select write
    wr("w_out_clr", BASE + 32'h04, 32'h0, 4'hF);
    wr("w_out_sel", BASE + 32'h04, 32'hAABB_CCDD, 4'b0101);
    rd("r_out_sel", BASE + 32'h04, 32'h00BB_00DD);

    // Rising edge on pad 2
    wr("w_rise", BASE + 32'h10, 32'h4, 4'hF);
    rd("r_rise", BASE + 32'h10, 32'h4);
    @(negedge clk); io_in = 32'h4;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("irq_early", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_set", {31'b0, irq}, 32'd1);
    rd("r_stat", BASE + 32'h18, 32'h4);
    rd("r_in", BASE + 32'h0C, 32'h4);
    chk("irq_before_clr", {31'b0, irq}, 32'd1);
    wr("w_stat_clr", BASE + 32'h18, 32'h4, 4'hF);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd("r_stat_clr", BASE + 32'h18, 32'h0);

    // Collision: W1C on the same edge that a new rise is captured
    @(negedge clk); io_in = 32'h0;
    repeat (4) @(posedge clk);
    @(negedge clk); io_in = 32'h4;
    repeat (4) @(posedge clk); #1;
    chk("irq_pre_coll", {31'b0, irq}, 32'd1);
    @(negedge clk); io_in = 32'h0;
    repeat (4) @(posedge clk);
    @(negedge clk); io_in = 32'h4;
    @(posedge clk); @(posedge clk);
    wr("w_stat_coll", BASE + 32'h18, 32'h4, 4'hF);
    chk("irq_coll", {31'b0, irq}, 32'd1);
    rd("r_stat_coll", BASE + 32'h18, 32'h4);

    // Decode
    rd("r_id", BASE + 32'h1C, IDV);
    rd("r_outside", BASE + 32'h40, 32'h0);
    wr("w_in", BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    rd("r_in_keep", BASE + 32'h0C, 32'h4);
    wr("w_id", BASE + 32'h1C, 32'h0, 4'hF);
    rd("r_id_keep", BASE + 32'h1C, IDV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
